// File: rtl/serial_ctrl_defs_pkg.sv
// Shared FSM encoding for the bit-serial arithmetic controllers.
package serial_ctrl_defs_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } serial_state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder cell.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder reused LSB-first, one bit per clock.
module serial_adder_ctrl
  import serial_ctrl_defs_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  serial_state_e    state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_s, fa_cout;

  full_adder u_full_adder (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_cout)
  );

  // Next-state and datapath update; operands are only captured in idle.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sh_d = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          sum_d   = sum_sh_d;
          cout_d  = fa_cout;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8, 1 and 4.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  logic       start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int checks = 0;
  int failures = 0;

  logic [7:0] held_sum8 = '0;
  logic       held_cout8 = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full WIDTH=8 operation with cycle-exact busy/done/hold checks.
  task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        input logic [7:0] es, input logic ec, input string nm);
    a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0 || sum8 !== held_sum8 || cout8 !== held_cout8) begin
        failures++;
        $display("FAIL %s shift%0d: busy=%b done=%b sum=%h cout=%b want busy=1 done=0 sum=%h cout=%b",
                 nm, i, busy8, done8, sum8, cout8, held_sum8, held_cout8);
      end
      step();
    end
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0 || sum8 !== es || cout8 !== ec) begin
      failures++;
      $display("FAIL %s result: done=%b busy=%b sum=%h cout=%b want done=1 busy=0 sum=%h cout=%b",
               nm, done8, busy8, sum8, cout8, es, ec);
    end
    held_sum8 = es;
    held_cout8 = ec;
    step();
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL %s after: done=%b busy=%b want 0 0", nm, done8, busy8);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      failures++;
      $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
               busy8, done8, sum8, cout8);
    end
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || sum1 !== 1'b0 || cout1 !== 1'b0 ||
        busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== 4'h0 || cout4 !== 1'b0) begin
      failures++;
      $display("FAIL reset1_4: w1 %b%b%b%b w4 %b%b%h%b want all zero",
               busy1, done1, sum1, cout1, busy4, done4, sum4, cout4);
    end
    held_sum8 = '0;
    held_cout8 = 1'b0;
  endtask

  task automatic test_basic();
    do_op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "basic_5a_3c");
  endtask

  task automatic test_carry();
    do_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "carry_ff_01");
    do_op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "carry_ff_ff_1");
  endtask

  task automatic test_ignore_start();
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
      end
      if (i == 5) begin
        a8 = 8'hC3; b8 = 8'h7E;
      end
      step();
    end
    checks++;
    if (done8 !== 1'b1 || sum8 !== 8'h30 || cout8 !== 1'b0) begin
      failures++;
      $display("FAIL ignore_result: done=%b sum=%h cout=%b want 1 30 0", done8, sum8, cout8);
    end
    start8 = 1'b0;
    held_sum8 = 8'h30;
    held_cout8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== 8'h30) begin
        failures++;
        $display("FAIL ignore_idle%0d: done=%b busy=%b sum=%h want 0 0 30",
                 i, done8, busy8, sum8);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    step();
    for (int n = 1; n <= 28; n++) begin
      logic want;
      step();
      want = (n == 8) || (n == 18) || (n == 28);
      checks++;
      if (done8 !== want) begin
        failures++;
        $display("FAIL b2b_done n=%0d: done=%b want %b", n, done8, want);
      end
      if (done8 === 1'b1) begin
        pulses++;
        checks++;
        if (sum8 !== 8'h02 || cout8 !== 1'b0) begin
          failures++;
          $display("FAIL b2b_sum n=%0d: sum=%h cout=%b want 02 0", n, sum8, cout8);
        end
      end
    end
    start8 = 1'b0;
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL b2b_count: pulses=%0d want 3", pulses);
    end
    step();
    step();
    held_sum8 = 8'h02;
    held_cout8 = 1'b0;
  endtask

  task automatic test_mid_reset();
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
               busy8, done8, sum8, cout8);
    end
    held_sum8 = '0;
    held_cout8 = 1'b0;
    step();
    do_op8(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, "after_reset_03_04");
  endtask

  task automatic test_width1();
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL w1_shift: busy=%b done=%b want 1 0", busy1, done1);
    end
    step();
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || sum1 !== 1'b1 || cout1 !== 1'b1) begin
      failures++;
      $display("FAIL w1_result: done=%b busy=%b sum=%b cout=%b want 1 0 1 1",
               done1, busy1, sum1, cout1);
    end
    step();
    checks++;
    if (done1 !== 1'b0) begin
      failures++;
      $display("FAIL w1_after: done=%b want 0", done1);
    end
  endtask

  task automatic test_width4_sweep();
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          logic [4:0] exp_v;
          int         wait_n;
          exp_v = 5'(ia) + 5'(ib) + 5'(ic);
          a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
          step();
          start4 = 1'b0;
          wait_n = 0;
          while (done4 !== 1'b1 && wait_n < 10) begin
            step();
            wait_n++;
          end
          checks++;
          if (done4 !== 1'b1 || wait_n != 4 || {cout4, sum4} !== exp_v) begin
            failures++;
            $display("FAIL w4 %0d+%0d+%0d: done=%b wait=%0d got=%h want done=1 wait=4 %h",
                     ia, ib, ic, done4, wait_n, {cout4, sum4}, exp_v);
          end
          step();
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_width1();
    test_width4_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
